// File: rtl/video_crtc6845_pkg.sv
// Shared widths, register indices, reset defaults and output payload for the
// MC6845-style CRT controller.
package video_crtc6845_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned IDX_WIDTH     = 5;
  localparam int unsigned NUM_REGS      = 16;
  localparam int unsigned MA_WIDTH      = 14;
  localparam int unsigned RA_WIDTH      = 5;
  localparam int unsigned ROW_WIDTH     = 7;
  localparam int unsigned H_WIDTH       = 8;

  typedef logic [IDX_WIDTH-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_t;

  localparam reg_idx_t R0  = 5'd0;
  localparam reg_idx_t R1  = 5'd1;
  localparam reg_idx_t R2  = 5'd2;
  localparam reg_idx_t R3  = 5'd3;
  localparam reg_idx_t R4  = 5'd4;
  localparam reg_idx_t R5  = 5'd5;
  localparam reg_idx_t R6  = 5'd6;
  localparam reg_idx_t R7  = 5'd7;
  localparam reg_idx_t R8  = 5'd8;
  localparam reg_idx_t R9  = 5'd9;
  localparam reg_idx_t R10 = 5'd10;
  localparam reg_idx_t R11 = 5'd11;
  localparam reg_idx_t R12 = 5'd12;
  localparam reg_idx_t R13 = 5'd13;
  localparam reg_idx_t R14 = 5'd14;
  localparam reg_idx_t R15 = 5'd15;
  localparam reg_idx_t R16 = 5'd16;
  localparam reg_idx_t R17 = 5'd17;

  // PET 40-column power-on timing
  localparam reg_t REG_DEFAULT [NUM_REGS] = '{
    8'd49, 8'd40, 8'd41, 8'h0F, 8'd39, 8'd0, 8'd25, 8'd32,
    8'd0,  8'd7,  8'd0,  8'd0,  8'h10, 8'd0, 8'd0,  8'd0
  };

  typedef struct packed {
    logic [MA_WIDTH-1:0] ma;
    logic [RA_WIDTH-1:0] ra;
    logic                de;
    logic                h_sync;
    logic                v_sync;
  } video_out_t;

  // Implemented bits of each writable register
  function automatic reg_t reg_mask(input reg_idx_t idx);
    case (idx)
      R4, R7:   reg_mask = 8'h7F;
      R5, R9:   reg_mask = 8'h1F;
      R12, R14: reg_mask = 8'h3F;
      default:  reg_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/video_crtc6845_if.sv
// Wishbone B4 read-only register port of the CRT controller.
interface video_crtc6845_if
  import video_crtc6845_pkg::*;
;
  logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0]    wb_data_o;
  logic                     wb_we_i;
  logic                     wb_cycle_i;
  logic                     wb_strobe_i;
  logic                     wb_stall_o;
  logic                     wb_ack_o;

  modport master (
    output wb_addr_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    input  wb_data_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    output wb_data_o, wb_stall_o, wb_ack_o
  );
endinterface

// File: rtl/video_crtc6845.sv
// MC6845-style CRT controller: R0-R17 register file, raster counters, syncs,
// display enable and refresh address, advanced once per character enable.
module video_crtc6845
  import video_crtc6845_pkg::*;
(
  input  logic                  wb_clock_i,
  input  logic                  reset_i,
  video_crtc6845_if.slave       wb,
  input  logic                  clk_en_i,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic                  rs_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_oe,
  output logic                  h_sync_o,
  output logic                  v_sync_o,
  output logic                  de_o,
  output logic [MA_WIDTH-1:0]   ma_o,
  output logic [RA_WIDTH-1:0]   ra_o
);

  reg_idx_t               ar_q, ar_d;
  reg_t                   regs_q [NUM_REGS];
  reg_t                   regs_d [NUM_REGS];
  logic [H_WIDTH-1:0]     h_q, h_d;
  logic [RA_WIDTH-1:0]    ra_q, ra_d;
  logic [ROW_WIDTH-1:0]   row_q, row_d;
  logic                   adj_q, adj_d;
  logic [MA_WIDTH-1:0]    base_q, base_d;
  logic [4:0]             vs_q, vs_d;
  video_out_t             out_q, out_d;
  logic                   ack_q, ack_d;
  reg_t                   wb_data_q, wb_data_d;

  logic                   frame_start_c;
  logic [MA_WIDTH-1:0]    base_c;
  logic [4:0]             vs_width_c;
  logic [4:0]             vs_cur_c;
  logic [8:0]             hs_end_c;
  reg_t                   cpu_rd_c;
  reg_t                   wb_rd_c;
  reg_idx_t               wb_idx_c;
  logic                   unused_addr_bits;

  // Register readback; indices 16 and above (light pen, unimplemented) read 0
  assign cpu_rd_c = ar_q[4] ? '0 : regs_q[ar_q[3:0]];
  assign wb_idx_c = wb.wb_addr_i[IDX_WIDTH-1:0];
  assign wb_rd_c  = wb_idx_c[4] ? '0 : regs_q[wb_idx_c[3:0]];
  assign unused_addr_bits = ^wb.wb_addr_i[WB_ADDR_WIDTH-1:IDX_WIDTH];

  assign data_o  = rs_i ? cpu_rd_c : '0;
  assign data_oe = cs_i && !we_i;

  assign wb.wb_data_o  = wb_data_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_stall_o = 1'b0;

  assign ma_o     = out_q.ma;
  assign ra_o     = out_q.ra;
  assign de_o     = out_q.de;
  assign h_sync_o = out_q.h_sync;
  assign v_sync_o = out_q.v_sync;

  // CPU port: address register and masked data register writes
  always_comb begin
    ar_d   = ar_q;
    regs_d = regs_q;
    if (clk_en_i && cs_i && we_i) begin
      if (!rs_i) begin
        ar_d = data_i[IDX_WIDTH-1:0];
      end else if (!ar_q[4]) begin
        regs_d[ar_q[3:0]] = data_i & reg_mask(ar_q);
      end
    end
  end

  // Wishbone: single-cycle ack, reads latch the addressed register
  always_comb begin
    ack_d     = wb.wb_cycle_i && wb.wb_strobe_i;
    wb_data_d = wb_data_q;
    if (ack_d && !wb.wb_we_i) begin
      wb_data_d = wb_rd_c;
    end
  end

  // Raster counters; outputs describe the position held before this enable
  always_comb begin
    h_d    = h_q;
    ra_d   = ra_q;
    row_d  = row_q;
    adj_d  = adj_q;
    base_d = base_q;
    vs_d   = vs_q;
    out_d  = out_q;

    frame_start_c = (h_q == '0) && (ra_q == '0) && (row_q == '0) && !adj_q;
    base_c        = frame_start_c ? {regs_q[R12[3:0]][5:0], regs_q[R13[3:0]]} : base_q;
    vs_width_c    = (regs_q[R3[3:0]][7:4] == 4'd0) ? 5'd16 : {1'b0, regs_q[R3[3:0]][7:4]};
    vs_cur_c      = ((h_q == '0) && (ra_q == '0) && !adj_q &&
                     (row_q == regs_q[R7[3:0]][6:0])) ? vs_width_c : vs_q;
    hs_end_c      = 9'(regs_q[R2[3:0]]) + 9'(regs_q[R3[3:0]][3:0]);

    if (clk_en_i) begin
      out_d.ma     = base_c + MA_WIDTH'(h_q);
      out_d.ra     = ra_q;
      out_d.de     = (h_q < regs_q[R1[3:0]]) && (8'(row_q) < regs_q[R6[3:0]]) && !adj_q;
      out_d.h_sync = (9'(h_q) >= 9'(regs_q[R2[3:0]])) && (9'(h_q) < hs_end_c);
      out_d.v_sync = (vs_cur_c != '0);

      base_d = base_c;
      vs_d   = vs_cur_c;
      h_d    = h_q + 8'd1;

      if (h_q == regs_q[R0[3:0]]) begin
        h_d  = '0;
        vs_d = (vs_cur_c == '0) ? 5'd0 : vs_cur_c - 5'd1;
        if (adj_q) begin
          // >= keeps the adjust finite if R5 is lowered mid-adjust
          if (6'(ra_q) + 6'd1 >= 6'(regs_q[R5[3:0]][4:0])) begin
            adj_d = 1'b0;
            row_d = '0;
            ra_d  = '0;
          end else begin
            ra_d = ra_q + 5'd1;
          end
        end else if (ra_q == regs_q[R9[3:0]][4:0]) begin
          ra_d   = '0;
          base_d = base_c + MA_WIDTH'(regs_q[R1[3:0]]);
          if (row_q == regs_q[R4[3:0]][6:0]) begin
            if (regs_q[R5[3:0]][4:0] == 5'd0) begin
              row_d = '0;
            end else begin
              adj_d = 1'b1;
            end
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          ra_d = ra_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge wb_clock_i) begin
    if (reset_i) begin
      ar_q      <= '0;
      regs_q    <= REG_DEFAULT;
      h_q       <= '0;
      ra_q      <= '0;
      row_q     <= '0;
      adj_q     <= 1'b0;
      base_q    <= '0;
      vs_q      <= '0;
      out_q     <= '0;
      ack_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      ar_q      <= ar_d;
      regs_q    <= regs_d;
      h_q       <= h_d;
      ra_q      <= ra_d;
      row_q     <= row_d;
      adj_q     <= adj_d;
      base_q    <= base_d;
      vs_q      <= vs_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_video_crtc6845.sv
// Self-checking bench for video_crtc6845: register access plus raster timing
// against a position-based arithmetic model of the CRT frame.
module tb_video_crtc6845;
  import video_crtc6845_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en, cs, we, rs;
  logic [7:0]  din, dout;
  logic        doe, hs, vs, de;
  logic [13:0] ma;
  logic [4:0]  ra;

  video_crtc6845_if wbi();

  video_crtc6845 dut (
    .wb_clock_i (clk),
    .reset_i    (rst),
    .wb         (wbi),
    .clk_en_i   (clk_en),
    .cs_i       (cs),
    .we_i       (we),
    .rs_i       (rs),
    .data_i     (din),
    .data_o     (dout),
    .data_oe    (doe),
    .h_sync_o   (hs),
    .v_sync_o   (vs),
    .de_o       (de),
    .ma_o       (ma),
    .ra_o       (ra)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg [16];
  int k;
  bit prev_checked;

  // Expected outputs for the k-th enable after a frame-aligned start
  function automatic logic [21:0] exp_at(input int kk);
    int L, lines, rows, disp, fl, h, sl, row, rav, hw, vw, s0, mav;
    logic d, hsy, vsy, adj;
    L     = cfg[0] + 1;
    lines = cfg[9] + 1;
    rows  = cfg[4] + 1;
    disp  = rows * lines;
    fl    = disp + cfg[5];
    h     = kk % L;
    sl    = (kk / L) % fl;
    if (sl < disp) begin
      row = sl / lines; rav = sl % lines; adj = 1'b0;
    end else begin
      row = rows; rav = sl - disp; adj = 1'b1;
    end
    d   = (h < cfg[1]) && (row < cfg[6]) && !adj;
    hw  = cfg[3] % 16;
    hsy = (h >= cfg[2]) && (h < cfg[2] + hw);
    vw  = cfg[3] / 16;
    if (vw == 0) vw = 16;
    s0  = cfg[7] * lines;
    vsy = (cfg[7] <= cfg[4]) && (sl >= s0) && (sl < s0 + vw);
    mav = (cfg[12] * 256 + cfg[13] + row * cfg[1] + h) % 16384;
    return {mav[13:0], rav[4:0], d, hsy, vsy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b0; cs = 1'b0; we = 1'b0; rs = 1'b0; din = 8'd0;
    wbi.wb_addr_i = '0; wbi.wb_we_i = 1'b0; wbi.wb_cycle_i = 1'b0; wbi.wb_strobe_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cfg = '{49, 40, 41, 15, 39, 0, 25, 32, 0, 7, 0, 0, 16, 0, 0, 0};
    k = 0;
    prev_checked = 1'b0;
  endtask

  task automatic cpu_write(input int idx, input int val);
    int m;
    cs = 1'b1; we = 1'b1; rs = 1'b0; din = 8'(idx); clk_en = 1'b1;
    tick();
    rs = 1'b1; din = 8'(val);
    tick();
    clk_en = 1'b0; cs = 1'b0; we = 1'b0; rs = 1'b0;
    k = k + 2;
    prev_checked = 1'b0;
    case (idx)
      4, 7:    m = 8'h7F;
      5, 9:    m = 8'h1F;
      12, 14:  m = 8'h3F;
      default: m = 8'hFF;
    endcase
    if (idx < 16) cfg[idx] = val & m;
  endtask

  task automatic wb_read(input int idx, output logic [7:0] d, output logic a1, output logic a2);
    wbi.wb_addr_i = 8'(idx); wbi.wb_we_i = 1'b0; wbi.wb_cycle_i = 1'b1; wbi.wb_strobe_i = 1'b1;
    tick();
    a1 = wbi.wb_ack_o; d = wbi.wb_data_o;
    wbi.wb_cycle_i = 1'b0; wbi.wb_strobe_i = 1'b0;
    tick();
    a2 = wbi.wb_ack_o;
  endtask

  task automatic enable(input bit chk, input int gap_max);
    int gaps;
    gaps = int'($urandom_range(0, gap_max));
    for (int g = 0; g < gaps; g++) begin
      tick();
      if (chk && prev_checked) begin
        n_cmp++;
        if ({ma, ra, de, hs, vs} !== exp_at(k - 1)) begin
          n_bad++;
          $display("FAIL idle_hold k=%0d got %h expected %h", k - 1, {ma, ra, de, hs, vs}, exp_at(k - 1));
        end
      end
    end
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    if (chk) begin
      n_cmp++;
      if ({ma, ra, de, hs, vs} !== exp_at(k)) begin
        n_bad++;
        $display("FAIL timing k=%0d got ma=%h ra=%0d de=%b hs=%b vs=%b expected %h",
                 k, ma, ra, de, hs, vs, exp_at(k));
      end
    end
    prev_checked = chk;
    k++;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic a1, a2;
    int idx;
    do_reset();
    n_cmp++;
    if ({ma, ra, de, hs, vs} !== 22'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h expected 0", {ma, ra, de, hs, vs});
    end
    wb_read(0, d, a1, a2);
    n_cmp++;
    if ({d, a1, a2} !== {8'd49, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_r0 got data=%0d ack=%b,%b expected 49 ack=1,0", d, a1, a2);
    end
    wb_read(12, d, a1, a2);
    n_cmp++;
    if ({d, a1, a2} !== {8'h10, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_r12 got data=%h ack=%b,%b expected 10 ack=1,0", d, a1, a2);
    end
    idx = int'($urandom_range(0, 15));
    wb_read(idx, d, a1, a2);
    n_cmp++;
    if (d !== 8'(cfg[idx])) begin
      n_bad++; $display("FAIL reset_default idx=%0d got %0d expected %0d", idx, d, cfg[idx]);
    end
    n_cmp++;
    if (wbi.wb_stall_o !== 1'b0) begin
      n_bad++; $display("FAIL wb_stall got %b expected 0", wbi.wb_stall_o);
    end
  endtask

  task automatic test_cpu_prog();
    logic [7:0] d, e;
    logic a1, a2;
    int idx, val;
    do_reset();
    cpu_write(1, 80);
    wb_read(1, d, a1, a2);
    n_cmp++;
    if (d !== 8'd80) begin n_bad++; $display("FAIL wb_r1 got %0d expected 80", d); end
    cs = 1'b1; we = 1'b0; rs = 1'b1; #1;
    n_cmp++;
    if ({dout, doe} !== {8'd80, 1'b1}) begin
      n_bad++; $display("FAIL cpu_read_data got %0d oe=%b expected 80 oe=1", dout, doe);
    end
    rs = 1'b0; #1;
    n_cmp++;
    if ({dout, doe} !== {8'd0, 1'b1}) begin
      n_bad++; $display("FAIL cpu_read_status got %0d oe=%b expected 0 oe=1", dout, doe);
    end
    we = 1'b1; #1;
    n_cmp++;
    if (doe !== 1'b0) begin n_bad++; $display("FAIL oe_on_write got %b expected 0", doe); end
    cs = 1'b0; we = 1'b0; #1;
    n_cmp++;
    if (doe !== 1'b0) begin n_bad++; $display("FAIL oe_no_cs got %b expected 0", doe); end
    // write strobes without a character enable must be ignored
    cs = 1'b1; we = 1'b1; rs = 1'b1; din = 8'h55;
    tick();
    cs = 1'b0; we = 1'b0; rs = 1'b0;
    wb_read(1, d, a1, a2);
    n_cmp++;
    if (d !== 8'd80) begin n_bad++; $display("FAIL no_enable_write got %0d expected 80", d); end
    // Wishbone writes are acknowledged and discarded
    wbi.wb_addr_i = 8'd1; wbi.wb_we_i = 1'b1; wbi.wb_cycle_i = 1'b1; wbi.wb_strobe_i = 1'b1;
    tick();
    a1 = wbi.wb_ack_o;
    wbi.wb_we_i = 1'b0; wbi.wb_cycle_i = 1'b0; wbi.wb_strobe_i = 1'b0;
    wb_read(1, d, a1, a2);
    n_cmp++;
    if ({a1, d} !== {1'b1, 8'd80}) begin
      n_bad++; $display("FAIL wb_write_discard got ack=%b r1=%0d expected ack=1 r1=80", a1, d);
    end
    for (int i = 0; i < 10; i++) begin
      idx = int'($urandom_range(0, 20));
      val = int'($urandom_range(0, 255));
      cpu_write(idx, val);
      e = (idx < 16) ? 8'(cfg[idx]) : 8'd0;
      wb_read(idx, d, a1, a2);
      n_cmp++;
      if (d !== e) begin n_bad++; $display("FAIL wb_rand idx=%0d got %h expected %h", idx, d, e); end
      cs = 1'b1; we = 1'b0; rs = 1'b1; #1;
      n_cmp++;
      if (dout !== e) begin n_bad++; $display("FAIL cpu_rand idx=%0d got %h expected %h", idx, dout, e); end
      cs = 1'b0; rs = 1'b0;
    end
  endtask

  task automatic test_default_timing();
    do_reset();
    for (int i = 0; i < 16100; i++) enable(1'b1, 0);
  endtask

  task automatic test_mid_frame_reset();
    int n;
    do_reset();
    n = int'($urandom_range(300, 2000));
    for (int i = 0; i < n; i++) enable(1'b1, 1);
    rst = 1'b1; clk_en = 1'b1;
    tick();
    rst = 1'b0; clk_en = 1'b0;
    n_cmp++;
    if ({ma, ra, de, hs, vs} !== 22'd0) begin
      n_bad++; $display("FAIL midreset_outputs got %h expected 0", {ma, ra, de, hs, vs});
    end
    cfg = '{49, 40, 41, 15, 39, 0, 25, 32, 0, 7, 0, 0, 16, 0, 0, 0};
    k = 0;
    prev_checked = 1'b0;
    for (int i = 0; i < 120; i++) enable(1'b1, 1);
  endtask

  // mode 0 random, 1 vertical adjust of 2, 2 refresh-address wrap, 3 no hsync
  task automatic test_config(input int mode);
    int nv [16];
    int wlist [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 12, 13};
    int fe, L, vmax, lo;
    do_reset();
    nv = cfg;
    nv[0]  = int'($urandom_range(24, 31));
    nv[1]  = int'($urandom_range(1, nv[0]));
    nv[2]  = int'($urandom_range(0, nv[0]));
    nv[4]  = int'($urandom_range(1, 5));
    nv[9]  = int'($urandom_range(0, 3));
    nv[5]  = (mode == 1) ? 2 : int'($urandom_range(0, 3));
    nv[6]  = int'($urandom_range(0, nv[4] + 1));
    nv[7]  = int'($urandom_range(0, nv[4]));
    vmax   = (nv[4] + 1 - nv[7]) * (nv[9] + 1);
    if (vmax > 15) vmax = 15;
    lo     = (mode == 3) ? 0 : int'($urandom_range(0, 15));
    nv[3]  = int'($urandom_range(1, vmax)) * 16 + lo;
    nv[12] = (mode == 2) ? 63 : int'($urandom_range(0, 63));
    nv[13] = (mode == 2) ? 255 : int'($urandom_range(0, 255));
    foreach (wlist[i]) cpu_write(wlist[i], nv[wlist[i]]);
    // first frame started on the old start address; check from the second
    L  = cfg[0] + 1;
    fe = ((cfg[4] + 1) * (cfg[9] + 1) + cfg[5]) * L;
    while (k < fe) enable(1'b0, 2);
    while (k < 2 * fe + L) enable(1'b1, 2);
  endtask

  initial begin
    test_reset();
    test_cpu_prog();
    test_default_timing();
    test_mid_frame_reset();
    test_config(0);
    test_config(1);
    test_config(2);
    test_config(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
